// File: rtl/im_fetch.sv
// Instruction fetch initiator: 1-cycle registered instruction memory, 2-entry skid buffer, redirect flush.
// Optional macro IF_ALIGN_CHK_EN adds out_fault_o and halts issue after a misaligned redirect target.
module im_fetch #(
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] im_addr_o,
    input  logic [31:0]       im_data_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [31:0]       out_pc_o
`ifdef IF_ALIGN_CHK_EN
    ,
    output logic              out_fault_o
`endif
);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] e0_instr_q, e0_instr_d, e0_pc_q, e0_pc_d;
    logic [31:0] e1_instr_q, e1_instr_d, e1_pc_q, e1_pc_d;
    logic [1:0]  count_q, count_d, count_after;
    logic [2:0]  occ;
    logic        deq, issue, halt;

`ifdef IF_ALIGN_CHK_EN
    logic fault_q, fault_d;
    assign halt        = fault_q;
    assign out_fault_o = fault_q;
`else
    assign halt = 1'b0;
`endif

    assign im_addr_o   = pc_q[ADDR_W+1:2];
    assign out_valid_o = (count_q != 2'd0);
    assign out_instr_o = e0_instr_q;
    assign out_pc_o    = e0_pc_q;

    // occupancy the buffer would reach if the word issued now came back next edge
    assign deq   = out_valid_o & out_ready_i;
    assign occ   = {1'b0, count_q} - {2'b00, deq} + {2'b00, inflight_q};
    assign issue = !redirect_valid_i && !halt && (occ < 3'd2);

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        e0_instr_d    = e0_instr_q;
        e0_pc_d       = e0_pc_q;
        e1_instr_d    = e1_instr_q;
        e1_pc_d       = e1_pc_q;
        count_d       = count_q;
        count_after   = count_q - {1'b0, deq};
`ifdef IF_ALIGN_CHK_EN
        fault_d       = fault_q;
`endif
        if (redirect_valid_i) begin
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            count_d = 2'd0;
`ifdef IF_ALIGN_CHK_EN
            fault_d = (redirect_pc_i[1:0] != 2'b00);
`endif
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
            if (deq) begin
                e0_instr_d = e1_instr_q;
                e0_pc_d    = e1_pc_q;
            end
            if (inflight_q) begin
                if (count_after == 2'd0) begin
                    e0_instr_d = im_data_i;
                    e0_pc_d    = inflight_pc_q;
                end else begin
                    e1_instr_d = im_data_i;
                    e1_pc_d    = inflight_pc_q;
                end
            end
            count_d = count_after + {1'b0, inflight_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            e0_instr_q    <= 32'd0;
            e0_pc_q       <= 32'd0;
            e1_instr_q    <= 32'd0;
            e1_pc_q       <= 32'd0;
            count_q       <= 2'd0;
`ifdef IF_ALIGN_CHK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            e0_instr_q    <= e0_instr_d;
            e0_pc_q       <= e0_pc_d;
            e1_instr_q    <= e1_instr_d;
            e1_pc_q       <= e1_pc_d;
            count_q       <= count_d;
`ifdef IF_ALIGN_CHK_EN
            fault_q       <= fault_d;
`endif
        end
    end

endmodule
